// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES segments,
// each built from 4-bit CLA groups, with registered inter-segment carry and valid/ready flow.
module pipe_cla_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NG   = SEG / 4;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] v, c_q, ld, src_v, src_c, nxt_c;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [SEG+1:0]    seg_r [STAGES];
    logic              msb_c, ovf_q, zero_q;

    // Returns {carry out, carry into segment MSB, segment sum}.
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                               input logic ci);
        logic [SEG-1:0] g, p, c;
        logic [NG-1:0]  gg, gp;
        logic [NG:0]    gc;
        g     = x & y;
        p     = x ^ y;
        gc[0] = ci;
        for (int unsigned j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[NG], c[SEG-1], p ^ c};
    endfunction

    // Stage i may load if the final stage drains or any stage at or after i is empty.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            ld[i] = out_ready;
            for (int unsigned j = i; j < STAGES; j++) begin
                if (!v[j]) ld[i] = 1'b1;
            end
        end
    end

    always_comb begin
        src_v    = '0;
        src_c    = '0;
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub | cin;
        src_s[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k] = v[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = c_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_r[k] = cla_seg(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
        end
    end

    always_comb begin
        nxt_c = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt_s[k]               = src_s[k];
            nxt_s[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
            nxt_c[k]               = seg_r[k][SEG+1];
        end
    end

    assign msb_c = seg_r[LAST][SEG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v      <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k] <= src_a[k];
                        b_q[k] <= src_b[k];
                        s_q[k] <= nxt_s[k];
                        c_q[k] <= nxt_c[k];
                    end
                end
            end
            if (ld[LAST] && src_v[LAST]) begin
                ovf_q  <= msb_c ^ nxt_c[LAST];
                zero_q <= ~|nxt_s[LAST];
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[LAST];
    assign sum       = s_q[LAST];
    assign carry     = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub: directed vectors on STAGES=1/2/4 instances,
// streaming, backpressure and random soak on the STAGES=2 instance, plus mid-stream reset.
module tb_pipe_cla_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0;

    logic        in_ready, out_valid, carry, overflow, zero;
    logic [31:0] sum;
    logic        in_ready1, out_valid1, carry1, overflow1, zero1;
    logic [31:0] sum1;
    logic        in_ready4, out_valid4, carry4, overflow4, zero4;
    logic [31:0] sum4;

    int checks = 0;
    int failures = 0;
    logic [34:0] exp_q[$];

    pipe_cla_addsub #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry(carry), .overflow(overflow), .zero(zero));

    pipe_cla_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1),
        .carry(carry1), .overflow(overflow1), .zero(zero1));

    pipe_cla_addsub #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid4), .out_ready(1'b1), .sum(sum4),
        .carry(carry4), .overflow(overflow4), .zero(zero4));

    always #5 clk = ~clk;

    // Reference: {carry, overflow, zero, sum}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [31:0] ye;
        logic [32:0] full;
        logic        ovf;
        ye   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + {32'd0, (s ? 1'b1 : ci)};
        ovf  = (x[31] == ye[31]) && (full[31] != x[31]);
        return {full[32], ovf, (full[31:0] == 32'd0), full[31:0]};
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, carry, overflow, zero, sum} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", {out_valid, carry, overflow, zero, sum}, 36'd0);
        end
        checks++;
        if ({out_valid1, out_valid4} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid_aux got=%b exp=00", {out_valid1, out_valid4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, in_ready1, in_ready4} !== 3'b111) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=111", {in_ready, in_ready1, in_ready4});
        end
    endtask

    task automatic test_directed(input string name, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s, input logic [34:0] e);
        @(posedge clk);
        #1;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        checks++;
        if ({in_ready, in_ready1, in_ready4} !== 3'b111) begin
            failures++;
            $display("FAIL %s_in_ready got=%b exp=111", name, {in_ready, in_ready1, in_ready4});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid1, carry1, overflow1, zero1, sum1} !== {1'b1, e}) begin
            failures++;
            $display("FAIL %s_s1 got=%h exp=%h", name, {out_valid1, carry1, overflow1, zero1, sum1}, {1'b1, e});
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_s2_early got=%b exp=0", name, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, carry, overflow, zero, sum} !== {1'b1, e}) begin
            failures++;
            $display("FAIL %s_s2 got=%h exp=%h", name, {out_valid, carry, overflow, zero, sum}, {1'b1, e});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid4, carry4, overflow4, zero4, sum4} !== {1'b1, e}) begin
            failures++;
            $display("FAIL %s_s4 got=%h exp=%h", name, {out_valid4, carry4, overflow4, zero4, sum4}, {1'b1, e});
        end
        @(posedge clk);
    endtask

    task automatic test_stream(input string name, input int n, input int vpct, input int rpct,
                               input int hold);
        int          issued = 0, emitted = 0, cyc = 0;
        logic        held = 1'b0, exp_ir;
        logic [35:0] hv = '0;
        logic [34:0] e;
        exp_q.delete();
        while ((issued < n || exp_q.size() != 0) && cyc < 20000) begin
            @(posedge clk);
            #1;
            in_valid  = (issued < n) && (cyc < hold || $urandom_range(99) < vpct);
            a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom);
            out_ready = (cyc >= hold) && ($urandom_range(99) < rpct);
            @(negedge clk);
            exp_ir = out_ready || (exp_q.size() < 2);
            checks++;
            if (in_ready !== exp_ir) begin
                failures++;
                $display("FAIL %s_in_ready cyc=%0d got=%b exp=%b", name, cyc, in_ready, exp_ir);
            end
            if (held) begin
                checks++;
                if ({out_valid, carry, overflow, zero, sum} !== hv) begin
                    failures++;
                    $display("FAIL %s_stall_stable cyc=%0d got=%h exp=%h", name, cyc,
                             {out_valid, carry, overflow, zero, sum}, hv);
                end
            end
            held = out_valid && !out_ready;
            hv   = {out_valid, carry, overflow, zero, sum};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_spurious cyc=%0d got=%h exp=none", name, cyc, sum);
                end else begin
                    e = exp_q.pop_front();
                    emitted++;
                    if ({carry, overflow, zero, sum} !== e) begin
                        failures++;
                        $display("FAIL %s_result cyc=%0d got=%h exp=%h", name, cyc,
                                 {carry, overflow, zero, sum}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                issued++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (emitted !== n) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d (cycles=%0d)", name, emitted, n, cyc);
        end
        if (vpct == 100 && rpct == 100 && hold == 0) begin
            checks++;
            if (cyc !== n + 2) begin
                failures++;
                $display("FAIL %s_throughput got=%0d cycles exp=%0d", name, cyc, n + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        a = 32'h1234_5678; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, carry, overflow, zero, sum} !== 36'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=%h", {out_valid, carry, overflow, zero, sum}, 36'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_in_ready got=%b exp=1", in_ready);
        end
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_valid1, out_valid4} !== 3'b000) begin
                failures++;
                $display("FAIL midreset_reemit cyc=%0d got=%b exp=000", i, {out_valid, out_valid1, out_valid4});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        test_directed("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});
        test_directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        test_directed("add_cross", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'h0001_0001});
        test_stream("full_rate", 100, 100, 100, 0);
        test_stream("backpressure", 3, 100, 100, 5);
        test_stream("soak", 1000, 70, 60, 0);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
